fetch_unit: RTL

Instruction fetch stage directly upstream of the PC register. Each cycle it reads the current `PCOut` and fetches the instruction word at that address from instruction memory using a req/ack handshake. It holds the word in an instruction register until decode accepts it. It drives the PC's `PCInA` input (sequential next address) and the `PCWrite` enable so the PC advances once per fetched instruction.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_reg16.sv | 20 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and default PC increment.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [15:0] PC_STEP_DEFAULT = 16'd2;

endpackage

// File: rtl/fetch_unit_reg16.sv
// 16-bit enabled register with asynchronous active-high clear; holds the fetched instruction word.
module reg16
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 16'h0000;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads PCOut, fetches over a req/ack memory port, holds the word for decode
// and pulses PCWrite once per fetched instruction.
//
// state | meaning
// LOAD  | latch PCOut into addr_q
// REQ   | memory request outstanding at addr_q; flush marks the returning word for discard
// HOLD  | IR holds a valid instruction until decode takes it or a flush redirects
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] PC_STEP = PC_STEP_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] PCOut,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] IR,
    output logic        ir_valid,
    input  logic        ir_taken,
    output logic [15:0] PCInA,
    output logic        PCWrite,
    output logic [15:0] fetch_count
);

    fetch_state_t state, state_nx;

    logic [15:0] addr_q;
    logic [15:0] pcina_q;
    logic [15:0] count_q;
    logic        drop_q;
    logic        pcw_q;
    logic        mem_req_q;
    logic        ir_valid_q;
    logic        ir_load;
    logic        count_en;

    always_comb begin
        state_nx = state;
        ir_load  = 1'b0;
        count_en = 1'b0;
        case (state)
            LOAD: begin
                if (!flush) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                // A flushed request still runs to its ack; the word is simply not kept.
                if (mem_ack) begin
                    if (flush || drop_q) begin
                        state_nx = LOAD;
                    end else begin
                        ir_load  = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nx = LOAD;
                end else if (ir_taken) begin
                    count_en = 1'b1;
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            addr_q     <= 16'h0000;
            pcina_q    <= 16'h0000;
            count_q    <= 16'h0000;
            drop_q     <= 1'b0;
            pcw_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                addr_q <= PCOut;
            end
            if (ir_load) begin
                pcina_q <= addr_q + PC_STEP;
            end
            if (count_en) begin
                count_q <= count_q + 16'd1;
            end
            pcw_q      <= ir_load;
            drop_q     <= (state == REQ) && (state_nx == REQ) && (drop_q || flush);
            mem_req_q  <= (state_nx == REQ);
            ir_valid_q <= (state_nx == HOLD);
        end
    end

    reg16 u_ir (
        .clk (CLK),
        .rst (reset),
        .en  (ir_load),
        .d   (mem_rdata),
        .q   (IR)
    );

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign ir_valid    = ir_valid_q;
    assign PCInA       = pcina_q;
    assign PCWrite     = pcw_q & ~flush;
    assign fetch_count = count_q;

endmodule
